// File: rtl/reg_bank_bus_ctrl.sv
// Round-robin controller sharing one tri-state register bank bus among
// several requesters; sequences read, write and preset accesses.
module reg_bank_bus_ctrl #(
    parameter int NrOfBits = 32,
    parameter int NrOfRegs = 4,
    parameter int AddrBits = 2,
    parameter int NrOfReqs = 2
) (
    input  logic                         Clock,
    input  logic                         Reset,
    input  logic                         Tick,
    input  logic [NrOfReqs-1:0]          req,
    input  logic [2*NrOfReqs-1:0]        op,
    input  logic [AddrBits*NrOfReqs-1:0] addr,
    input  logic [NrOfBits*NrOfReqs-1:0] wdata,
    output logic [NrOfReqs-1:0]          gnt,
    output logic [NrOfReqs-1:0]          ack,
    output logic                         err,
    output logic [NrOfBits-1:0]          rdata,
    output logic [NrOfRegs-1:0]          reg_cs,
    output logic [NrOfRegs-1:0]          reg_ce,
    output logic [NrOfRegs-1:0]          reg_pre,
    output logic [NrOfBits-1:0]          reg_d,
    input  logic [NrOfBits-1:0]          bus_in
);

    localparam int PW = (NrOfReqs > 1) ? $clog2(NrOfReqs) : 1;

    typedef enum logic [1:0] {
        IDLE,
        ACCESS,
        DONE
    } state_e;

    state_e                state_q;
    logic [PW-1:0]         ptr_q;
    logic [PW-1:0]         win_d;
    logic [PW-1:0]         ptr_d;
    logic [1:0]            op_q;
    logic [AddrBits-1:0]   addr_q;
    logic [NrOfBits-1:0]   wdata_q;
    logic                  armed_q;
    logic [NrOfReqs-1:0]   gnt_q;
    logic [NrOfReqs-1:0]   ack_q;
    logic                  err_q;
    logic [NrOfBits-1:0]   rdata_q;
    logic [NrOfRegs-1:0]   cs_q;
    logic [NrOfRegs-1:0]   ce_q;
    logic [NrOfRegs-1:0]   pre_q;
    logic [NrOfBits-1:0]   d_q;
    logic                  in_rng;
    logic                  is_wr;
    logic                  is_pre;
    logic [NrOfRegs-1:0]   sel;

    always_comb begin
        int  idx;
        logic found;
        win_d = ptr_q;
        found = 1'b0;
        idx   = 0;
        for (int k = 0; k < NrOfReqs; k++) begin
            idx = (int'(ptr_q) + k) % NrOfReqs;
            if (!found && req[idx]) begin
                found = 1'b1;
                win_d = PW'(idx);
            end
        end
        ptr_d = (int'(win_d) == NrOfReqs - 1) ? '0 : win_d + 1'b1;
    end

    assign in_rng = (32'(addr_q) < 32'(NrOfRegs));
    assign is_wr  = (op_q == 2'b01);
    assign is_pre = (op_q == 2'b10);
    // Out-of-range addresses decode to no register so nothing toggles.
    assign sel    = in_rng ? (NrOfRegs'(1) << addr_q) : '0;

    always_ff @(posedge Clock) begin
        if (Reset) begin
            state_q <= IDLE;
            ptr_q   <= '0;
            op_q    <= '0;
            addr_q  <= '0;
            wdata_q <= '0;
            armed_q <= 1'b0;
            gnt_q   <= '0;
            ack_q   <= '0;
            err_q   <= 1'b0;
            rdata_q <= '0;
            cs_q    <= '1;
            ce_q    <= '0;
            pre_q   <= '0;
            d_q     <= '0;
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (|req) begin
                        op_q    <= op[2*int'(win_d) +: 2];
                        addr_q  <= addr[AddrBits*int'(win_d) +: AddrBits];
                        wdata_q <= wdata[NrOfBits*int'(win_d) +: NrOfBits];
                        gnt_q   <= NrOfReqs'(1) << win_d;
                        ptr_q   <= ptr_d;
                        armed_q <= 1'b0;
                        state_q <= ACCESS;
                    end
                end
                ACCESS: begin
                    if (!armed_q) begin
                        armed_q <= 1'b1;
                        if (is_wr) begin
                            ce_q <= sel;
                            d_q  <= wdata_q;
                        end else if (is_pre) begin
                            pre_q <= sel;
                        end else begin
                            cs_q <= ~sel;
                        end
                    end else if (!is_wr || !in_rng || Tick) begin
                        // Bus is still driven on this edge, so capture now.
                        if (!is_wr && !is_pre && in_rng) begin
                            rdata_q <= bus_in;
                        end
                        err_q   <= !in_rng;
                        ack_q   <= gnt_q;
                        cs_q    <= '1;
                        ce_q    <= '0;
                        pre_q   <= '0;
                        state_q <= DONE;
                    end
                end
                DONE: begin
                    ack_q   <= '0;
                    gnt_q   <= '0;
                    err_q   <= 1'b0;
                    state_q <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign gnt     = gnt_q;
    assign ack     = ack_q;
    assign err     = err_q;
    assign rdata   = rdata_q;
    assign reg_cs  = cs_q;
    assign reg_ce  = ce_q;
    assign reg_pre = pre_q;
    assign reg_d   = d_q;

endmodule

// File: tb/tb_reg_bank_bus_ctrl.sv
// Randomized and directed bench for reg_bank_bus_ctrl with a behavioural
// register bank on the bus and a transaction-level reference model.
module tb_reg_bank_bus_ctrl;

    localparam int NB = 32;
    localparam int NR = 4;
    localparam int AB = 3;
    localparam int NQ = 2;

    logic          Clock = 1'b0;
    logic          Reset;
    logic          Tick;
    logic [NQ-1:0] req;
    logic [2*NQ-1:0] op;
    logic [AB*NQ-1:0] addr;
    logic [NB*NQ-1:0] wdata;
    logic [NQ-1:0] gnt;
    logic [NQ-1:0] ack;
    logic          err;
    logic [NB-1:0] rdata;
    logic [NR-1:0] reg_cs;
    logic [NR-1:0] reg_ce;
    logic [NR-1:0] reg_pre;
    logic [NB-1:0] reg_d;
    logic [NB-1:0] bus_in;

    reg_bank_bus_ctrl #(
        .NrOfBits(NB), .NrOfRegs(NR), .AddrBits(AB), .NrOfReqs(NQ)
    ) dut (
        .Clock(Clock), .Reset(Reset), .Tick(Tick),
        .req(req), .op(op), .addr(addr), .wdata(wdata),
        .gnt(gnt), .ack(ack), .err(err), .rdata(rdata),
        .reg_cs(reg_cs), .reg_ce(reg_ce), .reg_pre(reg_pre),
        .reg_d(reg_d), .bus_in(bus_in)
    );

    always #5 Clock = ~Clock;

    // Physical register bank seen by the controller.
    logic [NB-1:0] bank [NR] = '{default: '0};

    always @(posedge Clock) begin
        for (int i = 0; i < NR; i++) begin
            if (reg_pre[i]) bank[i] <= '1;
            else if (reg_ce[i] && Tick) bank[i] <= reg_d;
        end
    end

    always_comb begin
        bus_in = '0;
        for (int i = 0; i < NR; i++)
            if (!reg_cs[i]) bus_in = bus_in | bank[i];
    end

    // Reference model state.
    logic [NB-1:0] mem_m [NR] = '{default: '0};
    logic [NB-1:0] rdata_m = '0;
    int            ptr_m = 0;

    int n_chk = 0;
    int n_fail = 0;

    logic [1:0]    t_op   [NQ];
    logic [AB-1:0] t_addr [NQ];
    logic [NB-1:0] t_data [NQ];

    task automatic check(input string tag, input logic [31:0] obs,
                         input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic check_inv();
        check("cs_single", 32'($countones(~reg_cs) <= 1), 32'd1);
        check("ce_pre_excl", 32'((reg_ce != 0) && (reg_pre != 0)), 32'd0);
        check("ce_single", 32'($countones(reg_ce) <= 1), 32'd1);
        check("pre_single", 32'($countones(reg_pre) <= 1), 32'd1);
    endtask

    function automatic int winner(input logic [NQ-1:0] m);
        for (int k = 0; k < NQ; k++)
            if (m[(ptr_m + k) % NQ]) return (ptr_m + k) % NQ;
        return 0;
    endfunction

    task automatic run_set(input logic [NQ-1:0] mask_in, input int tl);
        logic [NQ-1:0] mask;
        logic [NR-1:0] oh, noh;
        int cyc, last, nleft, w, ce_n, cs_n, pre_n, lat;
        bit first, wr, pr, rd, inr;
        mask = mask_in;
        nleft = $countones(mask);
        @(posedge Clock); #1;
        req   = mask;
        op    = {t_op[1], t_op[0]};
        addr  = {t_addr[1], t_addr[0]};
        wdata = {t_data[1], t_data[0]};
        Tick  = 1'($urandom);
        w = winner(mask);
        cyc = 0; last = 0; first = 1'b1;
        ce_n = 0; cs_n = 0; pre_n = 0;
        while (nleft > 0 && cyc < 200) begin
            @(posedge Clock); #1;
            cyc++;
            check_inv();
            wr  = (t_op[w] == 2'b01);
            pr  = (t_op[w] == 2'b10);
            rd  = !wr && !pr;
            inr = (t_addr[w] < AB'(NR));
            oh  = NR'(1) << t_addr[w];
            noh = ~oh;
            if (gnt != 0) check("gnt", gnt, 1 << w);
            if (reg_cs != '1) begin
                cs_n++;
                check("cs_sel", reg_cs, noh);
            end
            if (reg_ce != 0) begin
                ce_n++;
                check("ce_sel", reg_ce, oh);
                check("reg_d", reg_d, t_data[w]);
            end
            if (reg_pre != 0) begin
                pre_n++;
                check("pre_sel", reg_pre, oh);
            end
            if (ack != 0) begin
                lat = (first ? 3 : 4) + ((wr && inr) ? tl : 0);
                check("ack", ack, 1 << w);
                check("ack_gnt", gnt, 1 << w);
                check("latency", cyc - last, lat);
                check("err", err, !inr);
                if (inr) begin
                    if (rd) rdata_m = mem_m[t_addr[w]];
                    else if (wr) mem_m[t_addr[w]] = t_data[w];
                    else mem_m[t_addr[w]] = '1;
                end
                check("rdata", rdata, rdata_m);
                check("cs_cycles", cs_n, (rd && inr) ? 1 : 0);
                check("ce_cycles", ce_n, (wr && inr) ? tl + 1 : 0);
                check("pre_cycles", pre_n, (pr && inr) ? 1 : 0);
                req[w] = 1'b0;
                mask[w] = 1'b0;
                nleft--;
                ptr_m = (w + 1) % NQ;
                last = cyc;
                first = 1'b0;
                ce_n = 0; cs_n = 0; pre_n = 0;
                if (nleft > 0) w = winner(mask);
            end
            if (reg_ce != 0) Tick = (ce_n > tl);
            else Tick = 1'($urandom);
        end
        check("timeout", nleft, 0);
    endtask

    task automatic set_req(input int r, input logic [1:0] o,
                           input logic [AB-1:0] a, input logic [NB-1:0] d);
        t_op[r] = o;
        t_addr[r] = a;
        t_data[r] = d;
    endtask

    initial begin
        Reset = 1'b1; Tick = 1'b0; req = '0;
        op = '0; addr = '0; wdata = '0;
        set_req(0, 2'b00, '0, '0);
        set_req(1, 2'b00, '0, '0);
        repeat (3) @(posedge Clock);
        #1;
        check("rst_gnt", gnt, 0);
        check("rst_ack", ack, 0);
        check("rst_err", err, 0);
        check("rst_rdata", rdata, 0);
        check("rst_cs", reg_cs, 4'hF);
        check("rst_ce", reg_ce, 0);
        check("rst_pre", reg_pre, 0);
        check("rst_d", reg_d, 0);
        Reset = 1'b0;

        // Simultaneous reads right after reset: requester 0 first.
        set_req(0, 2'b00, 3'd0, '0);
        set_req(1, 2'b00, 3'd1, '0);
        run_set(2'b11, 0);

        set_req(0, 2'b01, 3'd2, 32'hDEADBEEF);
        run_set(2'b01, 0);
        set_req(0, 2'b00, 3'd2, '0);
        run_set(2'b01, 0);

        // Pointer now 1: requester 1 must win this pair.
        set_req(0, 2'b00, 3'd2, '0);
        set_req(1, 2'b01, 3'd3, 32'h12345678);
        run_set(2'b11, 0);

        set_req(1, 2'b01, 3'd0, 32'h0BADF00D);
        run_set(2'b10, 4);

        set_req(0, 2'b10, 3'd1, '0);
        run_set(2'b01, 0);
        set_req(1, 2'b00, 3'd1, '0);
        run_set(2'b10, 0);

        set_req(0, 2'b00, 3'd5, '0);
        run_set(2'b01, 0);
        set_req(1, 2'b01, 3'd6, 32'h55AA55AA);
        run_set(2'b10, 2);

        // Reset while a write waits for Tick.
        @(posedge Clock); #1;
        req = 2'b10;
        op = {2'b01, 2'b00};
        addr = {3'd3, 3'd0};
        wdata = {32'hCAFEF00D, 32'h0};
        Tick = 1'b0;
        repeat (3) begin
            @(posedge Clock); #1;
            check_inv();
        end
        check("pre_rst_ce", reg_ce, 4'b1000);
        Reset = 1'b1;
        @(posedge Clock); #1;
        check("mid_rst_gnt", gnt, 0);
        check("mid_rst_ce", reg_ce, 0);
        check("mid_rst_cs", reg_cs, 4'hF);
        check("mid_rst_ack", ack, 0);
        check("mid_rst_pre", reg_pre, 0);
        Reset = 1'b0;
        req = '0;
        ptr_m = 0;
        rdata_m = '0;

        set_req(0, 2'b00, 3'd3, '0);
        run_set(2'b01, 0);

        for (int it = 0; it < 40; it++) begin
            for (int r = 0; r < NQ; r++)
                set_req(r, 2'($urandom_range(0, 3)),
                        AB'($urandom_range(0, 5)), $urandom);
            run_set(2'($urandom_range(1, 3)), $urandom_range(0, 3));
        end

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/reg_bank_bus_ctrl.md
Name: reg_bank_bus_ctrl

Overview:
- Shares a bank of tri-state-output bank registers (async-preset/reset flip-flop registers with cs, ClockEnable, Tick and pre pins) among several requesters over one shared data bus.
- Round-robin arbitration between requesters; sequences each read, write or preset access.
- Drives per-register cs, ClockEnable and pre so that at most one register drives the bus at any time.
- Sits between the CPU/accelerator masters and the register bank in the recognition datapath.

Parameters:
- NrOfBits, 32, register/data width.
- NrOfRegs, 4, registers in the bank (2..16).
- AddrBits, 2, register address width (≥ clog2(NrOfRegs)).
- NrOfReqs, 2, requesters (2..4).

Ports:
- Clock  in  1  system clock; all logic on rising edge.
- Reset  in  1  synchronous, active-high.
- Tick  in  1  global write-qualify strobe; registers capture only when ClockEnable&Tick.
- req  in  NrOfReqs  per-requester request; held high until that requester's ack.
- op  in  2*NrOfReqs  per-requester op: 00 read, 01 write, 10 preset (all ones), 11 treated as read.
- addr  in  AddrBits*NrOfReqs  per-requester register index.
- wdata  in  NrOfBits*NrOfReqs  per-requester write data.
- gnt  out  NrOfReqs  one-hot; high from grant until ack, inclusive.
- ack  out  NrOfReqs  one-cycle completion pulse to the granted requester.
- err  out  1  valid with ack; 1 = addr ≥ NrOfRegs.
- rdata  out  NrOfBits  read result; valid in the ack cycle, held until the next ack.
- reg_cs  out  NrOfRegs  per-register chip select; 1 = output high-Z, 0 = drive bus.
- reg_ce  out  NrOfRegs  per-register ClockEnable.
- reg_pre  out  NrOfRegs  per-register preset pulse.
- reg_d  out  NrOfBits  shared write data to all register D inputs.
- bus_in  in  NrOfBits  shared tri-state read bus from the register Q outputs.

Behaviour:
- All outputs are registered.
- Reset values: state IDLE; gnt 0, ack 0, err 0, rdata 0; reg_cs all ones; reg_ce 0; reg_pre 0; reg_d 0; round-robin pointer 0.
- FSM states: IDLE, ACCESS, DONE.
- IDLE:
  - If any req is set, pick the winner by round-robin starting at the pointer.
  - Latch the winner's op, addr and wdata; set its gnt; move the pointer to winner+1 (mod NrOfReqs); go to ACCESS.
  - No req: stay in IDLE.
- ACCESS, read: clear reg_cs[addr] for exactly one cycle, then go to DONE.
- ACCESS, write:
  - reg_d = latched wdata; set reg_ce[addr].
  - Hold both in ACCESS until a cycle with Tick=1 (the register captures on that edge), then go to DONE.
  - If Tick is already 1, ACCESS lasts one cycle.
- ACCESS, preset: set reg_pre[addr] for exactly one cycle; Tick is ignored; then go to DONE.
- DONE:
  - Read: rdata <= bus_in, sampled on the DONE cycle's edge while reg_cs[addr] is still 0.
  - Pulse ack[winner] for one cycle; drop gnt; release all cs, ce and pre; return to IDLE.
- Latency from req to ack:
  - Read: 3 cycles.
  - Preset: 3 cycles.
  - Write: 3 + number of Tick-low cycles spent in ACCESS.
- Bus safety invariants:
  - At most one reg_cs bit is 0 at any time; all ones outside a read.
  - reg_ce and reg_pre are never set simultaneously.
  - reg_ce and reg_pre are never set for more than one register.
- Out-of-range addr: no cs, ce or pre asserted; ACCESS lasts one cycle; ack with err=1; rdata unchanged.
- A granted transaction always completes, even if req drops mid-flight; a requester may re-request in the cycle after its ack.
- Simultaneous requests: the requester at or after the pointer wins; the others wait in line.
- Reset mid-operation: the next cycle shows reset values; no ack; an in-progress write is abandoned (register contents are whatever the last Tick edge left).
- Back-to-back: a request pending at ack time is arbitrated in the following IDLE cycle (minimum 1 idle cycle between transactions).

Test Plan:
- Reset, then req0 write addr 2 data 0xDEADBEEF with Tick=1 → reg_ce=0b0100 for one cycle with reg_d=0xDEADBEEF; ack0 in cycle 3. Then read addr 2 → reg_cs=0b1011 for one cycle; rdata=0xDEADBEEF with ack0 in cycle 3.
- req0 and req1 both high from reset, both reads → req0 granted first and req1 second; a later simultaneous pair grants req1 first (pointer=1). Check at most one reg_cs bit is 0 throughout.
- Write with Tick low for 4 cycles, then high → reg_ce held for 5 cycles; ack on cycle 7 after req.
- Preset addr 1 → reg_pre=0b0010 for exactly one cycle; a following read returns 0xFFFFFFFF.
- Read addr 5 with NrOfRegs=4, AddrBits=3 → no reg_cs, reg_ce or reg_pre activity; ack with err=1; rdata unchanged.
- Reset asserted while a write is waiting for Tick → next cycle: gnt 0, reg_ce 0, reg_cs all ones, no ack; a fresh request is then served normally.
